// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: fetches frame bytes from the Tx buffer and serialises
// opening flag, zero-stuffed data, optional CRC-16/X.25 FCS and closing flag.
module hdlc_tx_sequencer #(
  parameter int unsigned MAX_BYTES = 126,
  parameter logic [15:0] FCS_INIT  = 16'hFFFF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic       Tx_FCSen,
  input  logic [7:0] Tx_FrameSize,
  output logic       Tx_RdBuff,
  input  logic [7:0] Tx_Data,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done,
  output logic       Tx_Busy
);

  localparam int unsigned SIZE_W = 8;
  localparam int unsigned CRC_W  = 16;
  localparam logic [SIZE_W-1:0] MAX_B   = SIZE_W'(MAX_BYTES);
  localparam logic [7:0]        FLAG    = 8'h7E;
  localparam logic [CRC_W-1:0]  CRC_POLY = 16'h8408;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_FCS   = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [2:0]        ones_q, ones_d;
  logic [SIZE_W-1:0] left_q, left_d;
  logic [7:0]        cur_q, cur_d;
  logic [7:0]        pref_q, pref_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              fcs_en_q, fcs_en_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              rd_dly_q;
  logic              valid_q, valid_d;
  logic              aborted_q, aborted_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [3:0]        bit_inc;
  logic [SIZE_W-1:0] size_clamp;
  logic              in_frame;
  logic              go_abort, next_byte, emit, emit_data, line_bit;

  // One CRC-16/X.25 step, LSB-first reflected form.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic [CRC_W-1:0] s;
    s = c >> 1;
    if (c[0] ^ b) s = s ^ CRC_POLY;
    return s;
  endfunction

  assign bit_inc    = bit_q + 4'd1;
  assign size_clamp = (Tx_FrameSize > MAX_B) ? MAX_B : Tx_FrameSize;
  assign in_frame   = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_FCS);

  // Registers describe the bit currently on the line; next-state logic picks the following bit.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    ones_d    = ones_q;
    left_d    = left_q;
    cur_d     = cur_q;
    pref_d    = pref_q;
    crc_d     = crc_q;
    fcs_en_d  = fcs_en_q;
    aborted_d = aborted_q;
    tx_d      = 1'b1;
    rd_d      = 1'b0;
    done_d    = 1'b0;
    go_abort  = 1'b0;
    next_byte = 1'b0;
    emit      = 1'b0;
    emit_data = 1'b0;
    line_bit  = 1'b0;

    if (rd_dly_q && in_frame) pref_d = Tx_Data;

    case (state_q)
      ST_IDLE: begin
        if (Tx_Enable && (size_clamp != '0)) begin
          state_d   = ST_START;
          bit_d     = 4'd0;
          left_d    = size_clamp;
          fcs_en_d  = Tx_FCSen;
          aborted_d = 1'b0;
          crc_d     = FCS_INIT;
          ones_d    = 3'd0;
          tx_d      = FLAG[0];
          rd_d      = 1'b1;
        end
      end
      ST_START: begin
        if (Tx_AbortFrame) go_abort = 1'b1;
        else if (bit_q == 4'd7) next_byte = 1'b1;
        else begin
          bit_d = bit_inc;
          tx_d  = FLAG[bit_inc[2:0]];
        end
      end
      ST_DATA, ST_FCS: begin
        if (Tx_AbortFrame) go_abort = 1'b1;
        else if (ones_q == 3'd5) begin
          // Stuffed zero: bit position holds, run of ones restarts.
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if ((state_q == ST_DATA) && (bit_q != 4'd7)) begin
          bit_d     = bit_inc;
          emit      = 1'b1;
          emit_data = 1'b1;
          line_bit  = cur_q[bit_inc[2:0]];
        end else if ((state_q == ST_DATA) && (left_q != '0)) begin
          next_byte = 1'b1;
        end else if ((state_q == ST_DATA) && fcs_en_q) begin
          state_d  = ST_FCS;
          bit_d    = 4'd0;
          emit     = 1'b1;
          line_bit = ~crc_q[0];
        end else if ((state_q == ST_FCS) && (bit_q != 4'd15)) begin
          bit_d    = bit_inc;
          emit     = 1'b1;
          line_bit = ~crc_q[bit_inc];
        end else begin
          state_d = ST_END;
          bit_d   = 4'd0;
          tx_d    = FLAG[0];
        end
      end
      ST_END: begin
        if (bit_q == 4'd7) begin
          state_d = ST_IDLE;
          bit_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_inc;
          tx_d  = FLAG[bit_inc[2:0]];
        end
      end
      ST_ABORT: begin
        bit_d = bit_inc;
        if (bit_q == 4'd7) begin
          state_d = ST_IDLE;
          bit_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = 4'd0;
      end
    endcase

    if (next_byte) begin
      state_d   = ST_DATA;
      bit_d     = 4'd0;
      cur_d     = pref_q;
      left_d    = left_q - SIZE_W'(1);
      rd_d      = (left_q != SIZE_W'(1));
      emit      = 1'b1;
      emit_data = 1'b1;
      line_bit  = pref_q[0];
    end

    if (emit) begin
      tx_d   = line_bit;
      ones_d = line_bit ? 3'(ones_q + 3'd1) : 3'd0;
    end
    if (emit_data) crc_d = crc_step(crc_q, line_bit);

    if (go_abort) begin
      state_d   = ST_ABORT;
      bit_d     = 4'd0;
      tx_d      = 1'b0;
      rd_d      = 1'b0;
      aborted_d = 1'b1;
    end

    valid_d = (state_d == ST_START) || (state_d == ST_DATA) ||
              (state_d == ST_FCS) || (state_d == ST_END);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      bit_q     <= 4'd0;
      ones_q    <= 3'd0;
      left_q    <= '0;
      cur_q     <= 8'd0;
      pref_q    <= 8'd0;
      crc_q     <= FCS_INIT;
      fcs_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      rd_dly_q  <= 1'b0;
      valid_q   <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      ones_q    <= ones_d;
      left_q    <= left_d;
      cur_q     <= cur_d;
      pref_q    <= pref_d;
      crc_q     <= crc_d;
      fcs_en_q  <= fcs_en_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      rd_dly_q  <= rd_q;
      valid_q   <= valid_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_RdBuff       = rd_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx_Done         = done_q;
  assign Tx_Busy         = busy_q;

endmodule

// File: doc/hdlc_tx_sequencer.md
Name: hdlc_tx_sequencer

Overview:
Transmit-side controller for the HDLC core. On a start command it fetches frame bytes from the Tx buffer through a read-strobe handshake. It serialises the frame one bit per clock as: opening flag, data with zero insertion, optional CRC-16 FCS, closing flag. It also generates the abort pattern and the idle pattern, and drives Tx, Tx_ValidFrame and Tx_AbortedTrans toward the line and the status register.

Parameters:
MAX_BYTES, 126, upper limit on frame length; larger Tx_FrameSize values are clamped to this.
FCS_INIT, 16'hFFFF, CRC register preset at the start of each frame.

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous active-low reset
Tx_Enable  input  1  one-cycle start command, sampled only in IDLE
Tx_AbortFrame  input  1  one-cycle abort request
Tx_FCSen  input  1  append FCS; sampled with Tx_Enable and held for the frame
Tx_FrameSize  input  8  number of data bytes; sampled with Tx_Enable
Tx_RdBuff  output  1  one-cycle read strobe to the Tx buffer
Tx_Data  input  8  buffer byte, valid the cycle after Tx_RdBuff
Tx  output  1  serial line, LSB first
Tx_ValidFrame  output  1  high from the first opening-flag bit to the last closing-flag bit
Tx_AbortedTrans  output  1  sticky abort status
Tx_Done  output  1  one-cycle pulse on normal frame completion
Tx_Busy  output  1  state != IDLE

Behaviour:
- Reset values: Tx=1, Tx_RdBuff=0, Tx_ValidFrame=0, Tx_AbortedTrans=0, Tx_Done=0, Tx_Busy=0, state=IDLE, CRC=FCS_INIT, counters=0.
- Reset asserted mid-frame: the frame is dropped immediately and the line returns to idle ones.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT. Each emits one bit per cycle.
- IDLE:
  - Tx=1 (idle pattern: continuous ones).
  - Tx_Enable with clamped size >= 1: go to START_FLAG next cycle, latch size and FCSen, clear Tx_AbortedTrans.
  - Tx_Enable with size 0: ignored.
  - Tx_AbortFrame: ignored.
  - Tx_Enable and Tx_AbortFrame together: start the frame.
- START_FLAG: emits 0,1,1,1,1,1,1,0 (8'h7E). Tx_RdBuff is high in its first cycle. Then go to DATA.
- DATA:
  - Latched byte shifts out LSB first.
  - Tx_RdBuff pulses in the cycle bit 0 of the current byte is driven, if bytes remain. The byte is captured into the prefetch register the next cycle.
  - After the last byte: go to FCS if FCSen, else END_FLAG.
- Zero insertion:
  - Applies in DATA and FCS only.
  - The ones-counter counts consecutive 1 bits. It is cleared at DATA entry and by any emitted 0.
  - When the counter reaches 5, the next cycle emits a 0, the bit index does not advance, and the counter clears.
  - The counter carries across byte boundaries and across DATA->FCS.
  - A pending stuff bit after the final FCS/data bit is emitted before END_FLAG.
  - Flags and abort are never stuffed.
- FCS:
  - CRC-16/X.25: reflected polynomial 16'h8408, LSB-first, updated with each unstuffed data bit.
  - Transmit ~CRC, 16 bits, LSB first, low byte first.
- END_FLAG: emits 8'h7E. In the cycle after its last bit: state=IDLE, Tx_Done=1 for one cycle.
- Tx_AbortFrame in START_FLAG, DATA or FCS:
  - The next cycle enters ABORT and Tx_AbortedTrans=1.
  - ABORT emits 0 followed by seven 1s, then goes to IDLE. No Tx_Done.
  - No further Tx_RdBuff. An outstanding read's data is discarded.
  - Tx_ValidFrame=0 from ABORT entry.
- Tx_AbortFrame during END_FLAG or ABORT: ignored.
- Tx_Enable while busy: ignored.
- Tx_AbortedTrans clears only on reset or on the next accepted Tx_Enable.
- Frame length in cycles, counted by Tx_ValidFrame: 16 + 8*N + 16*FCSen + stuffed bits.

Test Plan:
- Size=1, Tx_Data=8'h00, FCSen=0:
  - Tx = 01111110 00000000 01111110, then ones.
  - Tx_ValidFrame high 24 cycles; one Tx_RdBuff; Tx_Done 1 cycle after.
- Size=1, 8'hFF, FCSen=0:
  - Data field = 11111 0 111 (9 cycles); Tx_ValidFrame 25 cycles.
  - No stuffing inside either flag.
- Size=9, "123456789" (8'h31..8'h39), FCSen=1:
  - FCS bytes 8'h6E then 8'h90 on line, LSB first.
  - Exactly 9 Tx_RdBuff pulses; stuffed-bit count matches the reference model.
- Size=4, Tx_AbortFrame in 3rd data byte:
  - Next cycle Tx = 0,1,1,1,1,1,1,1, then idle ones.
  - Tx_AbortedTrans=1 and stays; Tx_ValidFrame drops; no Tx_Done.
  - Next Tx_Enable clears Tx_AbortedTrans.
- Tx_Enable with size 0; Tx_Enable mid-frame; Tx_AbortFrame in IDLE and during END_FLAG:
  - No state change; the current frame completes with a bit-exact sequence.
- Rst low mid-DATA:
  - Tx=1, Tx_ValidFrame=0, Tx_Busy=0 while reset is low.
  - After release, a fresh size-1 frame is bit-exact.
